// File: rtl/nand_check_pkg.sv
// Shared types, constants and the reference NAND function for the NAND cell checker.
package nand_check_pkg;

  localparam int unsigned NUM_VEC = 4;
  localparam int unsigned VEC_W   = 2;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Plain-vector aliases of the enum so the FSM register stays a simple logic vector
  localparam logic [STATE_W-1:0] ST_IDLE = IDLE;
  localparam logic [STATE_W-1:0] ST_RUN  = RUN;
  localparam logic [STATE_W-1:0] ST_DONE = DONE;

  // Value a healthy 2-input NAND cell produces for the given inputs
  function automatic logic nand_expected(input logic a, input logic b);
    return ~(a & b);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Hold-window timer: ticks once every SETTLE_CYCLES+1 enabled cycles, restarted by load.
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES);
  // With no settle time every enabled cycle is a sample cycle
  localparam logic TICK_AT_START = (SETTLE_CYCLES == 0);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_d;

  // Next count; tick is registered so it is high during the last cycle of each window
  always_comb begin
    cnt_d  = cnt;
    tick_d = tick;
    if (load) begin
      cnt_d  = '0;
      tick_d = TICK_AT_START;
    end else if (en) begin
      if (tick) begin
        cnt_d  = '0;
        tick_d = TICK_AT_START;
      end else begin
        cnt_d  = cnt + CNT_W'(1);
        tick_d = (cnt_d == LAST_CNT);
      end
    end
  end

  // Counter and tick registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      tick <= tick_d;
    end
  end

endmodule

// File: rtl/nand_gate_checker.sv
// Sweeps a 2-input NAND cell through its truth table, samples its output after a
// settle window and scores each sample against the expected NAND value.
module nand_gate_checker
  import nand_check_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             y_obs,
  output logic             a_drv,
  output logic             b_drv,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       fail_vec
);

  localparam int unsigned PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);
  localparam logic [VEC_W-1:0]  LAST_VEC  = VEC_W'(NUM_VEC - 1);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_d;
  logic [VEC_W-1:0]   idx;
  logic [VEC_W-1:0]   idx_d;
  logic [PASS_W-1:0]  pass_cnt;
  logic [PASS_W-1:0]  pass_cnt_d;

  logic               a_d;
  logic               b_d;
  logic               busy_d;
  logic               done_d;
  logic               pass_d;
  logic [ERR_W-1:0]   err_d;
  logic [3:0]         fail_d;

  logic               timer_load_c;
  logic               timer_en_c;
  logic               tick;
  logic               mismatch_c;
  logic [ERR_W-1:0]   err_inc_c;

  // Hold-window timer for the vector currently being driven
  settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load_c),
    .en    (timer_en_c),
    .tick  (tick)
  );

  // Next-state, counter and scoreboard logic
  always_comb begin
    state_d      = state;
    idx_d        = idx;
    pass_cnt_d   = pass_cnt;
    a_d          = a_drv;
    b_d          = b_drv;
    busy_d       = busy;
    done_d       = 1'b0;
    pass_d       = pass;
    err_d        = err_cnt;
    fail_d       = fail_vec;
    timer_load_c = 1'b0;
    timer_en_c   = 1'b0;

    // A floating or unknown cell output must never be scored as correct
    mismatch_c = (y_obs !== nand_expected(a_drv, b_drv));
    err_inc_c  = (err_cnt == '1) ? err_cnt : err_cnt + ERR_W'(1);

    case (state)
      ST_IDLE: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          state_d      = ST_RUN;
          busy_d       = 1'b1;
          idx_d        = '0;
          pass_cnt_d   = '0;
          err_d        = '0;
          fail_d       = '0;
          pass_d       = 1'b0;
          timer_load_c = 1'b1;
        end
      end

      ST_RUN: begin
        timer_en_c = 1'b1;
        if (tick) begin
          if (mismatch_c) begin
            err_d       = err_inc_c;
            fail_d[idx] = 1'b1;
          end
          idx_d      = idx + VEC_W'(1);
          {a_d, b_d} = idx_d;
          if (idx == LAST_VEC) begin
            if (pass_cnt == LAST_PASS) begin
              state_d = ST_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              a_d     = 1'b0;
              b_d     = 1'b0;
              pass_d  = (err_d == '0);
            end else begin
              pass_cnt_d = pass_cnt + PASS_W'(1);
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        a_d     = 1'b0;
        b_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      pass_cnt <= '0;
      a_drv    <= 1'b0;
      b_drv    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      fail_vec <= '0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      pass_cnt <= pass_cnt_d;
      a_drv    <= a_d;
      b_drv    <= b_d;
      busy     <= busy_d;
      done     <= done_d;
      pass     <= pass_d;
      err_cnt  <= err_d;
      fail_vec <= fail_d;
    end
  end

endmodule

// File: tb/tb_nand_gate_checker.sv
// Bench for nand_gate_checker: two configurations driven by a table-based cell model.
module tb_nand_gate_checker;

  localparam int unsigned SET_A = 2, PAS_A = 1, ERRW_A = 8;
  localparam int unsigned SET_B = 1, PAS_B = 3, ERRW_B = 3;

  logic clk     = 1'b0;
  logic rst_n   = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic        y_a, a_a, b_a, busy_a, done_a, pass_a;
  logic [7:0]  err_a;
  logic [3:0]  fv_a;
  logic        y_b, a_b, b_b, busy_b, done_b, pass_b;
  logic [2:0]  err_b;
  logic [3:0]  fv_b;

  // Cell models: output value looked up by the {a,b} currently driven
  logic tbl_a [4];
  logic tbl_b [4];
  assign y_a = tbl_a[{a_a, b_a}];
  assign y_b = tbl_b[{a_b, b_b}];

  logic [16:0] obs_a;
  logic [16:0] obs_b;
  assign obs_a = {busy_a, done_a, a_a, b_a, pass_a, fv_a, err_a};
  assign obs_b = {busy_b, done_b, a_b, b_b, pass_b, fv_b, 5'b0, err_b};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nand_gate_checker #(
    .SETTLE_CYCLES (SET_A), .PASSES (PAS_A), .ERR_W (ERRW_A)
  ) dut_a (
    .clk (clk), .rst_n (rst_n), .start (start_a), .y_obs (y_a),
    .a_drv (a_a), .b_drv (b_a), .busy (busy_a), .done (done_a),
    .pass (pass_a), .err_cnt (err_a), .fail_vec (fv_a)
  );

  nand_gate_checker #(
    .SETTLE_CYCLES (SET_B), .PASSES (PAS_B), .ERR_W (ERRW_B)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .start (start_b), .y_obs (y_b),
    .a_drv (a_b), .b_drv (b_b), .busy (busy_b), .done (done_b),
    .pass (pass_b), .err_cnt (err_b), .fail_vec (fv_b)
  );

  // One full run on instance inst, checking every cycle against the truth-table model.
  // pulse_at >= 0 raises start for one cycle at that point of the run.
  task automatic run_sweep(input int inst, input int pulse_at, input string name);
    int s1, np, lat, emax, n, e, v;
    logic [3:0]  f;
    logic        m [4];
    logic [16:0] exp_v, obs;
    logic        yv;
    s1   = (inst == 0) ? int'(SET_A) + 1 : int'(SET_B) + 1;
    np   = (inst == 0) ? int'(PAS_A) : int'(PAS_B);
    emax = (inst == 0) ? (1 << ERRW_A) - 1 : (1 << ERRW_B) - 1;
    lat  = 4 * np * s1;
    for (int k = 0; k < 4; k++) begin
      yv   = (inst == 0) ? tbl_a[k] : tbl_b[k];
      m[k] = (yv !== ((k == 3) ? 1'b0 : 1'b1));
    end
    if (inst == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    if (inst == 0) start_a = 1'b0; else start_b = 1'b0;
    for (int c = 0; c <= lat + 1; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      n = (c >= lat) ? 4 * np : c / s1;
      e = 0;
      f = 4'b0000;
      for (int j = 0; j < n; j++) begin
        if (m[j % 4]) begin
          if (e < emax) e++;
          f[j % 4] = 1'b1;
        end
      end
      v = (c / s1) % 4;
      if (c < lat)       exp_v = {1'b1, 1'b0, 2'(v), 1'b0, f, 8'(e)};
      else if (c == lat) exp_v = {1'b0, 1'b1, 2'b00, (e == 0), f, 8'(e)};
      else               exp_v = {1'b0, 1'b0, 2'b00, (e == 0), f, 8'(e)};
      obs = (inst == 0) ? obs_a : obs_b;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s cyc=%0d got={busy,done,a,b,pass,fv,err}=%b want=%b", name, c, obs, exp_v);
      end
      if (inst == 0) start_a = (c == pulse_at); else start_b = (c == pulse_at);
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if (obs_a !== 17'd0) begin errors++; $display("FAIL reset_a got=%b want=0", obs_a); end
    checks++;
    if (obs_b !== 17'd0) begin errors++; $display("FAIL reset_b got=%b want=0", obs_b); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_healthy;
    tbl_a = '{1'b1, 1'b1, 1'b1, 1'b0};
    run_sweep(0, -1, "healthy_a");
    tbl_b = '{1'b1, 1'b1, 1'b1, 1'b0};
    run_sweep(1, -1, "healthy_b");
  endtask

  task automatic test_stuck1;
    tbl_a = '{1'b1, 1'b1, 1'b1, 1'b1};
    run_sweep(0, -1, "stuck1_a");
  endtask

  task automatic test_stuck0;
    tbl_a = '{1'b0, 1'b0, 1'b0, 1'b0};
    run_sweep(0, -1, "stuck0_a");
    tbl_b = '{1'b0, 1'b0, 1'b0, 1'b0};
    run_sweep(1, -1, "stuck0_sat_b");
  endtask

  task automatic test_float;
    tbl_a = '{1'bz, 1'bz, 1'bz, 1'bz};
    run_sweep(0, -1, "float_a");
  endtask

  task automatic test_start_ignored;
    tbl_a = '{1'b1, 1'b1, 1'b1, 1'b0};
    run_sweep(0, 4, "start_in_run_a");
    tbl_b = '{1'b1, 1'b0, 1'b1, 1'b0};
    run_sweep(1, 10, "start_in_run_b");
  endtask

  task automatic test_back_to_back;
    int first_done, second_done;
    first_done  = -1;
    second_done = -1;
    tbl_a   = '{1'b1, 1'b1, 1'b1, 1'b0};
    start_a = 1'b1;
    for (int c = 0; c < 60 && first_done < 0; c++) begin
      @(posedge clk); #1;
      if (done_a === 1'b1) first_done = c;
    end
    checks++;
    if (first_done != 12) begin errors++; $display("FAIL b2b_latency1 got=%0d want=12", first_done); end
    checks++;
    if ({pass_a, err_a} !== {1'b1, 8'd0}) begin
      errors++; $display("FAIL b2b_pass1 got=%b want=1_00000000", {pass_a, err_a});
    end
    @(posedge clk); #1;
    checks++;
    if ({busy_a, done_a, pass_a} !== 3'b001) begin
      errors++; $display("FAIL b2b_idle_gap got=%b want=001", {busy_a, done_a, pass_a});
    end
    @(posedge clk); #1;
    start_a = 1'b0;
    checks++;
    if ({busy_a, done_a, a_a, b_a, pass_a, err_a} !== 13'b1_0_00_0_00000000) begin
      errors++; $display("FAIL b2b_restart got=%b want=1000000000000", {busy_a, done_a, a_a, b_a, pass_a, err_a});
    end
    for (int k = 1; k < 60 && second_done < 0; k++) begin
      @(posedge clk); #1;
      if (done_a === 1'b1) second_done = k;
    end
    checks++;
    if (second_done != 12) begin errors++; $display("FAIL b2b_latency2 got=%0d want=12", second_done); end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset;
    tbl_a   = '{1'b1, 1'b1, 1'b1, 1'b0};
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if ({busy_a, a_a, b_a} !== 3'b110) begin
      errors++; $display("FAIL midrst_pre got=%b want=110", {busy_a, a_a, b_a});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_a !== 17'd0) begin errors++; $display("FAIL midrst_async got=%b want=0", obs_a); end
    @(posedge clk); #1;
    checks++;
    if (obs_a !== 17'd0) begin errors++; $display("FAIL midrst_hold got=%b want=0", obs_a); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs_a !== 17'd0) begin errors++; $display("FAIL midrst_release got=%b want=0", obs_a); end
    run_sweep(0, -1, "post_reset_a");
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        tbl_a[k] = 1'($urandom_range(0, 1));
        tbl_b[k] = 1'($urandom_range(0, 1));
      end
      if (r % 2 == 0) run_sweep(0, -1, "random_a");
      else            run_sweep(1, -1, "random_b");
    end
  endtask

  initial begin
    tbl_a = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl_b = '{1'b1, 1'b1, 1'b1, 1'b0};
    test_reset();
    test_healthy();
    test_stuck1();
    test_stuck0();
    test_float();
    test_start_ignored();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
